window_sequencer: RTL

- Controls the 7-line pixel buffer feeding the 7x7 convolution window.
- Accepts a raster pixel stream and generates line-buffer write enable, column address and rotating line select.
- Tracks row/column position, reports which physical line is oldest, and flags when a full KxK window is valid.
- Applies downstream backpressure to the pixel source. Sits between the pixel input and the line-buffer memory stage.

---
 rtl/window_sequencer_pkg.sv | 28 ++
 rtl/window_sequencer_if.sv | 42 ++++
 rtl/window_sequencer_raster_counter.sv | 67 ++++++
 rtl/window_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/window_sequencer_pkg.sv
// Shared types and helpers for the window sequencer.
//   state_t        : frame sequencing state (IDLE/FILL/RUN/DONE, 2 bits)
//   DEF_*          : default frame geometry and window size
//   onehot_to_idx  : converts a one-hot line select into a line index
package window_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_IMG_W = 1280;
    localparam int DEF_IMG_H = 720;
    localparam int DEF_K     = 7;

    // OR-reduction encoder: with exactly one bit set the result is its index.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            idx = idx | (onehot[i] ? 5'(i) : 5'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/window_sequencer_if.sv
// Pixel-side handshake, line-buffer write controls and window status of the
// window sequencer, bundled as one interface.
//   master : pixel source / window consumer side (drives valid, sof, win_ready)
//   slave  : the sequencer itself
interface window_sequencer_if #(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int K     = 7
);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int LINE_W = (K > 1) ? $clog2(K) : 1;

    logic              pix_valid_in;
    logic              sof_in;
    logic              pix_ready_out;
    logic              win_ready_in;
    logic              wr_en_out;
    logic [COL_W-1:0]  wr_addr_out;
    logic [K-1:0]      wr_line_sel_out;
    logic [LINE_W-1:0] oldest_line_out;
    logic              win_valid_out;
    logic [ROW_W-1:0]  win_row_out;
    logic [COL_W-1:0]  win_col_out;
    logic              frame_done_out;
    logic              sof_err_out;
    logic [1:0]        state_out;

    modport master (
        output pix_valid_in, sof_in, win_ready_in,
        input  pix_ready_out, wr_en_out, wr_addr_out, wr_line_sel_out,
               oldest_line_out, win_valid_out, win_row_out, win_col_out,
               frame_done_out, sof_err_out, state_out
    );

    modport slave (
        input  pix_valid_in, sof_in, win_ready_in,
        output pix_ready_out, wr_en_out, wr_addr_out, wr_line_sel_out,
               oldest_line_out, win_valid_out, win_row_out, win_col_out,
               frame_done_out, sof_err_out, state_out
    );
endinterface

// File: rtl/window_sequencer_raster_counter.sv
// Raster position counter for one frame.
//   clear   : return to (0,0) (end of frame handshake)
//   restart : the pixel being written is a new frame start, treat it as (0,0)
//   advance : a pixel is written at the current position this cycle
//   cur_col / cur_row : position of the pixel being written now
//   eol / eof : current pixel is the last of its line / of the frame
module raster_counter #(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             restart,
    input  logic             advance,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             eol,
    output logic             eof
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;

    // A restarting pixel overrides the stored position so it lands at (0,0).
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        if (restart) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = {ROW_W{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
    end

    assign eol     = (cur_col_s == COL_LAST);
    assign eof     = eol && (cur_row_s == ROW_LAST);
    assign cur_col = cur_col_s;
    assign cur_row = cur_row_s;

    // Position register: step past the written pixel, wrapping at line/frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (clear) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (advance) begin
            if (eol) begin
                col_r <= {COL_W{1'b0}};
                row_r <= eof ? {ROW_W{1'b0}} : cur_row_s + ROW_W'(1);
            end else begin
                col_r <= cur_col_s + COL_W'(1);
                row_r <= cur_row_s;
            end
        end
    end
endmodule

// File: rtl/window_sequencer.sv
// Window sequencer: steers a raster pixel stream into K rotating line
// buffers and flags when a full KxK window is resident.
//   clk, rst_n : clock, asynchronous active-low reset
//   sq (slave) : pixel handshake, line-buffer write strobe/address/line
//                select, oldest line, window valid/coordinates, frame_done
//                and sof_err pulses, state
module window_sequencer
    import window_sequencer_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K
) (
    input  logic              clk,
    input  logic              rst_n,
    window_sequencer_if.slave sq
);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int LINE_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [ROW_W-1:0] ROW_WIN0      = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_WIN0      = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(K - 2);
    localparam logic [K-1:0]     SEL_FIRST     = K'(1);

    state_t           state_r, state_next_s, pixel_state_s;
    logic             ready_s, accept_s, in_frame_s, write_s, restart_s;
    logic             sof_err_s, done_s, win_hit_s;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic             eol_s, eof_s;
    logic [K-1:0]     sel_r, cur_sel_s, rot_sel_s;
    logic [31:0]      sel_ext_s;
    logic [4:0]       sel_idx_s;
    logic             win_valid_r, frame_done_r, sof_err_r;
    logic [ROW_W-1:0] win_row_r;
    logic [COL_W-1:0] win_col_r;

    raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (done_s),
        .restart (restart_s),
        .advance (write_s),
        .cur_col (cur_col_s),
        .cur_row (cur_row_s),
        .eol     (eol_s),
        .eof     (eof_s)
    );

    // Source backpressure: stall only while a window waits for its consumer.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE:          ready_s = 1'b1;
            ST_FILL, ST_RUN:  ready_s = !(win_valid_r && !sq.win_ready_in);
            ST_DONE:          ready_s = 1'b0;
            default:          ready_s = 1'b0;
        endcase
    end

    assign accept_s   = sq.pix_valid_in && ready_s;
    assign in_frame_s = (state_r == ST_FILL) || (state_r == ST_RUN);
    assign write_s    = accept_s && (in_frame_s || sq.sof_in);
    assign restart_s  = accept_s && sq.sof_in;
    assign sof_err_s  = restart_s && in_frame_s;
    assign done_s     = (state_r == ST_DONE) && win_valid_r && sq.win_ready_in;
    assign win_hit_s  = (cur_row_s >= ROW_WIN0) && (cur_col_s >= COL_WIN0);

    // Line select seen by the written pixel, and its left rotation for the next line.
    always_comb begin
        cur_sel_s = sel_r;
        rot_sel_s = {K{1'b0}};
        if (restart_s) begin
            cur_sel_s = SEL_FIRST;
        end else begin
            cur_sel_s = sel_r;
        end
        for (int i = 0; i < K; i++) begin
            rot_sel_s[(i + 1) % K] = cur_sel_s[i];
        end
    end

    // Oldest line is the one after the line being written, modulo K.
    always_comb begin
        sel_ext_s          = 32'd0;
        sel_ext_s[K-1:0]   = cur_sel_s;
        sel_idx_s          = onehot_to_idx(sel_ext_s);
    end

    // State the frame is in after the current pixel has been written.
    always_comb begin
        pixel_state_s = ST_FILL;
        if (eof_s) begin
            pixel_state_s = ST_DONE;
        end else if ((cur_row_s >= ROW_WIN0) || (eol_s && (cur_row_s == ROW_FILL_LAST))) begin
            pixel_state_s = ST_RUN;
        end else begin
            pixel_state_s = ST_FILL;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (write_s) begin
                    state_next_s = pixel_state_s;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DONE: begin
                if (done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line select register: rotates at each written end of line, restarts with the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_FIRST;
        end else if (done_s) begin
            sel_r <= SEL_FIRST;
        end else if (write_s) begin
            sel_r <= eol_s ? rot_sel_s : cur_sel_s;
        end
    end

    // Window status: raised one cycle after its bottom-right pixel is written,
    // held until consumed; a written pixel without a window clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_r  <= 1'b0;
            win_row_r    <= {ROW_W{1'b0}};
            win_col_r    <= {COL_W{1'b0}};
            frame_done_r <= 1'b0;
            sof_err_r    <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            sof_err_r    <= sof_err_s;
            if (done_s) begin
                win_valid_r <= 1'b0;
            end else if (write_s) begin
                win_valid_r <= win_hit_s;
                if (win_hit_s) begin
                    win_row_r <= cur_row_s - ROW_WIN0;
                    win_col_r <= cur_col_s - COL_WIN0;
                end
            end else if (sq.win_ready_in) begin
                win_valid_r <= 1'b0;
            end
        end
    end

    assign sq.pix_ready_out   = ready_s;
    assign sq.wr_en_out       = write_s;
    assign sq.wr_addr_out     = cur_col_s;
    assign sq.wr_line_sel_out = cur_sel_s;
    assign sq.oldest_line_out = LINE_W'((sel_idx_s == 5'(K - 1)) ? 5'd0 : sel_idx_s + 5'd1);
    assign sq.win_valid_out   = win_valid_r;
    assign sq.win_row_out     = win_row_r;
    assign sq.win_col_out     = win_col_r;
    assign sq.frame_done_out  = frame_done_r;
    assign sq.sof_err_out     = sof_err_r;
    assign sq.state_out       = state_r;
endmodule
